debug_pio_out_ctrl: RTL and testbench
=====================================

DEBUG_PIO_OUT_CTRL -- requirements
Module: debug_pio_out_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 5, output port width, legal 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of DATA.
REQ-003 SHALL have parameter LEN_W, default 16, width of PULSE_LEN register/counter, legal 1..32.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe; write = chipselect & ~write_n.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, zero wait states.
REQ-011 SHALL have port out_port  output  WIDTH  current DATA register.
REQ-012 SHALL have port upd_strobe  output  1  one-cycle pulse when out_port changed value.

Function
REQ-013 SHALL decode address: 0 DATA (R/W), 1 SET (W), 2 CLEAR (W), 3 TOGGLE (W), 4 PULSE_MASK (R/W), 5 PULSE_LEN (R/W), 6 STATUS (RO), 7 reserved.
REQ-014 SHALL update on write: DATA <= wd; SET: DATA | wd; CLEAR: DATA & ~wd; TOGGLE: DATA ^ wd; wd = writedata[WIDTH-1:0], upper bits ignored.
REQ-015 SHALL make write effects visible on out_port the cycle after the write edge (1-cycle latency), no wait states.
REQ-016 SHALL drive readdata combinationally, zero-extended: addr 0-3 -> DATA; 4 -> PULSE_MASK; 5 -> PULSE_LEN; 6 -> {31'b0, pulse_active}; 7 -> 0; readdata independent of chipselect.
REQ-017 SHALL ignore writes to address 6 and 7.
REQ-018 SHALL start a pulse when a write to addr 0-3 yields new DATA with (new DATA & PULSE_MASK) != 0: pulse_active <= 1, counter <= max(PULSE_LEN,1).
REQ-019 SHALL decrement counter by 1 each cycle while pulse_active and no retrigger.
REQ-020 SHALL, at the edge where pulse_active and counter == 1 with no concurrent DATA write, set DATA <= DATA & ~PULSE_MASK, pulse_active <= 0, counter <= 0.
REQ-021 SHALL thereby hold masked bits high exactly max(PULSE_LEN,1) cycles as seen on out_port.
REQ-022 SHALL give a DATA write priority over expiry in the same cycle: DATA takes write result; retrigger per REQ-018, otherwise pulse_active <= 0.
REQ-023 SHALL restart (not extend additively) the counter on any retriggering write during an active pulse.
REQ-024 SHALL use the current PULSE_MASK at expiry; PULSE_MASK/PULSE_LEN writes mid-pulse SHALL NOT reload the counter.
REQ-025 SHALL, if a non-retriggering DATA write clears all masked bits during a pulse, set pulse_active <= 0.
REQ-026 SHALL assert upd_strobe for exactly one cycle, the cycle after any edge where DATA's registered value changed (write or expiry); unchanged-value writes SHALL NOT strobe.
REQ-027 SHALL treat PULSE_MASK = 0 as pulse mode disabled (DATA purely static).

Reset
REQ-028 SHALL asynchronously on reset_n low set DATA = RESET_VALUE, PULSE_MASK = 0, PULSE_LEN = 1, counter = 0, pulse_active = 0, upd_strobe = 0.
REQ-029 SHALL abort any active pulse on reset mid-operation with no expiry clear afterwards; release is synchronous to clk.
REQ-030 SHALL NOT strobe upd_strobe on the first edge after reset release.

Verification
REQ-031 SHALL verify: reset, WIDTH=5 -> out_port=0, readdata@0=0; write 0x3F to addr 0 -> out_port=0x1F, readdata=0x1F, upd_strobe one cycle.
REQ-032 SHALL verify: DATA=0x05; SET 0x02 -> 0x07; CLEAR 0x04 -> 0x03; TOGGLE 0x11 -> 0x12; SET 0x02 again -> no upd_strobe.
REQ-033 SHALL verify: PULSE_MASK=0x01, PULSE_LEN=3; SET 0x01 -> bit0 high exactly 3 cycles then 0; STATUS=1 during, 0 after; two upd_strobes.
REQ-034 SHALL verify: PULSE_LEN=4, SET 0x01, then SET 0x01 again 2 cycles later -> bit0 high 6 cycles total.
REQ-035 SHALL verify: PULSE_LEN=0 -> masked bit high 1 cycle; write to addr 0 on expiry cycle with 0x00 -> DATA=0, pulse_active=0.
REQ-036 SHALL verify: reset_n asserted mid-pulse -> immediate DATA=RESET_VALUE, STATUS=0, no later auto-clear event.

Source files
------------

// File: rtl/debug_pio_out_ctrl.sv
// Avalon-MM debug output port with SET/CLEAR/TOGGLE aliases and a
// self-clearing pulse mode on the bits selected by PULSE_MASK.
module debug_pio_out_ctrl #(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             upd_strobe
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             strobe_q, strobe_d;

  logic             wr;
  logic             data_wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] wr_val;
  logic [LEN_W-1:0] len_eff;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    wr      = chipselect & ~write_n;
    data_wr = wr & ~address[2];
    wd      = writedata[WIDTH-1:0];
    len_eff = (len_q == '0) ? LEN_W'(1) : len_q;

    case (address[1:0])
      2'd0:    wr_val = wd;
      2'd1:    wr_val = data_q | wd;
      2'd2:    wr_val = data_q & ~wd;
      default: wr_val = data_q ^ wd;
    endcase

    data_d   = data_q;
    mask_d   = mask_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    active_d = active_q;

    // A DATA write always wins over expiry; it either restarts or ends the pulse.
    if (data_wr) begin
      data_d = wr_val;
      if ((wr_val & mask_q) != '0) begin
        active_d = 1'b1;
        cnt_d    = len_eff;
      end else begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end else if (active_q) begin
      if (cnt_q == LEN_W'(1)) begin
        data_d   = data_q & ~mask_q;
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q - LEN_W'(1);
      end
    end

    if (wr && address == 3'd4) mask_d = wd;
    if (wr && address == 3'd5) len_d  = writedata[LEN_W-1:0];

    strobe_d = (data_d != data_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      len_q    <= LEN_W'(1);
      cnt_q    <= '0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3: readdata = 32'(data_q);
      3'd4:                   readdata = 32'(mask_q);
      3'd5:                   readdata = 32'(len_q);
      3'd6:                   readdata = {31'b0, active_q};
      default:                readdata = 32'b0;
    endcase
  end

  assign out_port   = data_q;
  assign upd_strobe = strobe_q;

endmodule

// File: tb/tb_debug_pio_out_ctrl.sv
// Bench for debug_pio_out_ctrl: register table, pulse-mode sequences and
// randomized traffic against a cycle-timestamp reference model.
module tb_debug_pio_out_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [4:0]  out_port;
  logic        upd_strobe;

  int checks = 0;
  int errors = 0;

  debug_pio_out_ctrl #(.WIDTH(5), .RESET_VALUE(5'h00), .LEN_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .upd_strobe (upd_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic [31:0] wd;
    logic [4:0]  exp_out;
    logic        exp_stb;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  // Reference model: pulse expiry tracked as an absolute edge number.
  logic [4:0]  m_data, m_mask;
  logic [15:0] m_len;
  logic        m_active, m_strobe;
  int          m_cyc, m_expire;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
    address    = a;
    chipselect = cs;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd6;
  endtask

  task automatic reset_dut();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    m_data = 5'h00; m_mask = 5'h00; m_len = 16'd1;
    m_active = 1'b0; m_strobe = 1'b0; m_cyc = 0; m_expire = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    if (a < 3'd4) return {27'b0, m_data};
    if (a == 3'd4) return {27'b0, m_mask};
    if (a == 3'd5) return {16'b0, m_len};
    if (a == 3'd6) return {31'b0, m_active};
    return 32'b0;
  endfunction

  task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] wd);
    logic [4:0] nd, w;
    logic       na;
    int         hold;
    m_cyc++;
    w  = wd[4:0];
    nd = m_data;
    na = m_active;
    if (cs && !wn && a < 3'd4) begin
      case (a)
        3'd0:    nd = w;
        3'd1:    nd = m_data | w;
        3'd2:    nd = m_data & ~w;
        default: nd = m_data ^ w;
      endcase
      if ((nd & m_mask) != 5'h00) begin
        na       = 1'b1;
        hold     = (m_len == 16'd0) ? 1 : int'(m_len);
        m_expire = m_cyc + hold;
      end else begin
        na = 1'b0;
      end
    end else if (m_active && m_cyc == m_expire) begin
      nd = m_data & ~m_mask;
      na = 1'b0;
    end
    if (cs && !wn && a == 3'd4) m_mask = w;
    if (cs && !wn && a == 3'd5) m_len  = wd[15:0];
    m_strobe = (nd != m_data);
    m_data   = nd;
    m_active = na;
  endtask

  initial begin
    int          hi_cnt, st_cnt, sb_cnt;
    logic [5:0]  pat;
    logic        r_cs, r_wn;
    logic [2:0]  r_a;
    logic [31:0] r_wd;

    tbl[0]  = '{3'd0, 1'b1, 32'h0000_003F, 5'h1F, 1'b1, 3'd0, 32'h1F};
    tbl[1]  = '{3'd0, 1'b1, 32'h0000_0005, 5'h05, 1'b1, 3'd1, 32'h05};
    tbl[2]  = '{3'd1, 1'b1, 32'h0000_0002, 5'h07, 1'b1, 3'd2, 32'h07};
    tbl[3]  = '{3'd2, 1'b1, 32'h0000_0004, 5'h03, 1'b1, 3'd3, 32'h03};
    tbl[4]  = '{3'd3, 1'b1, 32'h0000_0011, 5'h12, 1'b1, 3'd0, 32'h12};
    tbl[5]  = '{3'd1, 1'b1, 32'h0000_0002, 5'h12, 1'b0, 3'd0, 32'h12};
    tbl[6]  = '{3'd6, 1'b1, 32'h0000_00FF, 5'h12, 1'b0, 3'd6, 32'h00};
    tbl[7]  = '{3'd7, 1'b1, 32'h0000_00FF, 5'h12, 1'b0, 3'd7, 32'h00};
    tbl[8]  = '{3'd5, 1'b1, 32'h0001_2345, 5'h12, 1'b0, 3'd5, 32'h2345};
    tbl[9]  = '{3'd4, 1'b1, 32'hFFFF_FFE0, 5'h12, 1'b0, 3'd4, 32'h00};
    tbl[10] = '{3'd0, 1'b0, 32'h0000_0000, 5'h12, 1'b0, 3'd0, 32'h12};
    tbl[11] = '{3'd5, 1'b1, 32'h0000_0001, 5'h12, 1'b0, 3'd5, 32'h01};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 32'h0;
    @(negedge clk);
    chk("rst_out", out_port, 5'h00);
    chk("rst_rd0", readdata, 32'h0);
    chk("rst_stb", upd_strobe, 1'b0);
    address = 3'd5; #1;
    chk("rst_len", readdata, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_stb", upd_strobe, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_write(tbl[i].addr, tbl[i].wd, tbl[i].cs);
      address = tbl[i].rd_addr; #1;
      chk($sformatf("tbl%0d_out", i), out_port, tbl[i].exp_out);
      chk($sformatf("tbl%0d_stb", i), upd_strobe, tbl[i].exp_stb);
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      @(negedge clk);
      chk($sformatf("tbl%0d_stb1", i), upd_strobe, 1'b0);
    end

    // Basic pulse: mask bit0, length 3
    reset_dut();
    do_write(3'd4, 32'h1);
    do_write(3'd5, 32'h3);
    do_write(3'd1, 32'h1);
    st_cnt = 0; sb_cnt = 0; pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = out_port[0];
      st_cnt += int'(readdata[0]);
      sb_cnt += int'(upd_strobe);
      @(negedge clk);
    end
    chk("p3_pattern", pat, 6'b000111);
    chk("p3_status", st_cnt, 3);
    chk("p3_strobes", sb_cnt, 2);
    chk("p3_final_out", out_port, 5'h00);
    chk("p3_final_st", readdata, 32'h0);

    // Retrigger restarts the count
    do_write(3'd5, 32'h4);
    do_write(3'd1, 32'h1);
    hi_cnt = int'(out_port[0]);
    @(negedge clk);
    hi_cnt += int'(out_port[0]);
    do_write(3'd1, 32'h1);
    for (int i = 0; i < 8; i++) begin
      hi_cnt += int'(out_port[0]);
      @(negedge clk);
    end
    chk("retrig_hi", hi_cnt, 6);
    chk("retrig_final", out_port, 5'h00);

    // Zero length behaves as one cycle; writes on the expiry cycle win
    do_write(3'd5, 32'h0);
    do_write(3'd1, 32'h1);
    chk("l0_hi", out_port, 5'h01);
    chk("l0_st", readdata, 32'h1);
    @(negedge clk);
    chk("l0_lo", out_port, 5'h00);
    chk("l0_stb", upd_strobe, 1'b1);
    chk("l0_st0", readdata, 32'h0);
    do_write(3'd1, 32'h1);
    do_write(3'd0, 32'h0);
    chk("exp_wr_out", out_port, 5'h00);
    chk("exp_wr_st", readdata, 32'h0);
    chk("exp_wr_stb", upd_strobe, 1'b1);
    do_write(3'd1, 32'h1);
    do_write(3'd0, 32'h1);
    chk("exp_rt_out", out_port, 5'h01);
    chk("exp_rt_st", readdata, 32'h1);
    chk("exp_rt_stb", upd_strobe, 1'b0);
    @(negedge clk);
    chk("exp_rt_end", out_port, 5'h00);

    // Reset mid-pulse
    do_write(3'd5, 32'h5);
    do_write(3'd1, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", out_port, 5'h00);
    chk("mid_rst_st", readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    st_cnt = 0; sb_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      st_cnt += int'(readdata[0]);
      sb_cnt += int'(upd_strobe);
      hi_cnt += int'(out_port != 5'h00);
      @(negedge clk);
    end
    chk("post_rst_st", st_cnt, 0);
    chk("post_rst_stb", sb_cnt, 0);
    chk("post_rst_out", hi_cnt, 0);
    address = 3'd4; #1;
    chk("post_rst_mask", readdata, 32'h0);
    @(negedge clk);

    // Randomized traffic against the model
    reset_dut();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      chk("rnd_out", out_port, m_data);
      chk("rnd_stb", upd_strobe, m_strobe);
      r_cs = ($urandom_range(0, 3) != 0);
      r_wn = 1'($urandom_range(0, 1));
      r_a  = 3'($urandom_range(0, 7));
      r_wd = $urandom;
      if (r_a == 3'd5) r_wd[15:0] = 16'($urandom_range(0, 5));
      chipselect = r_cs; write_n = r_wn; address = r_a; writedata = r_wd;
      #1;
      chk("rnd_rd", readdata, m_rd(r_a));
      model_edge(r_cs, r_wn, r_a, r_wd);
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
